// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI flash READ (0x03) initiator with valid/ready byte output
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd1;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd2;
  localparam logic [2:0] ST_CS_HOLD   = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  gap_q, gap_d;
  logic [4:0]  bit_q, bit_d;
  // Bit 31 of the command word goes straight to flash_io0 at accept,
  // so only the remaining 31 bits need to be held here.
  logic [30:0] shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  hold_q, hold_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic        csb_q, csb_d;
  logic        sck_q, sck_d;
  logic        io0_q, io0_d;

  logic        phase_end;
  logic        stall;

  assign phase_end = (div_q == DIV_LAST);
  // A new byte may not start while the previous one is still unclaimed.
  assign stall     = rd_valid_q && !rd_ready && (bit_q == 5'd0);

  // Next-state logic for the transaction sequencer and SPI phase timing
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    csb_d      = csb_q;
    sck_d      = sck_q;
    io0_d      = io0_q;

    // A load later in this block overrides the clear.
    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          shift_d = {7'h03, req_addr};
          io0_d   = 1'b0;
          cnt_d   = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
          csb_d   = 1'b0;
          sck_d   = 1'b0;
          div_d   = 8'd0;
          bit_d   = 5'd0;
          state_d = ST_SHIFT_OUT;
        end
      end

      ST_SHIFT_OUT: begin
        if (phase_end) begin
          div_d = 8'd0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == 5'd31) begin
              bit_d   = 5'd0;
              io0_d   = 1'b0;
              state_d = ST_SHIFT_IN;
            end else begin
              bit_d   = bit_q + 5'd1;
              io0_d   = shift_q[30];
              shift_d = {shift_q[29:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_SHIFT_IN: begin
        if (phase_end) begin
          if (!sck_q) begin
            // While stalled div stays at its last value, so the rising
            // edge fires on the first cycle the holding register is free.
            if (!stall) begin
              div_d = 8'd0;
              sck_d = 1'b1;
              rx_d  = {rx_q[6:0], flash_io1};
            end
          end else begin
            div_d = 8'd0;
            sck_d = 1'b0;
            if (bit_q == 5'd7) begin
              bit_d      = 5'd0;
              hold_d     = rx_q;
              rd_valid_d = 1'b1;
              cnt_d      = cnt_q - 9'd1;
              if (cnt_q == 9'd1) begin
                state_d = ST_CS_HOLD;
              end
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_CS_HOLD: begin
        if (phase_end) begin
          div_d   = 8'd0;
          csb_d   = 1'b1;
          gap_d   = 8'd0;
          state_d = ST_GAP;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        csb_d   = 1'b1;
        sck_d   = 1'b0;
        io0_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset idles the bus immediately and drops any partial byte
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      div_q      <= 8'd0;
      gap_q      <= 8'd0;
      bit_q      <= 5'd0;
      shift_q    <= 31'd0;
      rx_q       <= 8'd0;
      hold_q     <= 8'd0;
      cnt_q      <= 9'd0;
      rd_valid_q <= 1'b0;
      csb_q      <= 1'b1;
      sck_q      <= 1'b0;
      io0_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      csb_q      <= csb_d;
      sck_q      <= sck_d;
      io0_q      <= io0_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rd_data   = hold_q;
  assign rd_valid  = rd_valid_q;
  assign flash_csb = csb_q;
  assign flash_clk = sck_q;
  assign flash_io0 = io0_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - directed self-checking bench for spi_flash_reader
module tb_spi_flash_reader;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'd0;
  logic [7:0]  req_len = 8'd0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0;
  logic        flash_io1 = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clock(clock), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1)
  );

  always #5 clock = ~clock;

  // Flash model: mem[i] = i ^ 0x5A except a few hand-placed bytes.
  logic [7:0]  mem [0:1023];
  int          fl_bits = 0;
  logic [31:0] fl_cmd = 32'd0;
  int          fl_idx;
  logic [9:0]  fl_a;
  logic [7:0]  fl_b;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h6F; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h0B;
    mem[4] = 8'hC3;
  end

  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) fl_bits = 0;
    else begin
      if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], flash_io0};
      fl_bits = fl_bits + 1;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && fl_bits >= 32) begin
      fl_idx = fl_bits - 32;
      fl_a = 10'(fl_cmd[23:0] + 24'(fl_idx / 8));
      fl_b = mem[fl_a];
      flash_io1 = fl_b[3'(7 - fl_idx % 8)];
    end
  end

  // Monitors, sampled on the falling system clock edge
  logic [7:0] rx_q[$];
  int sck_total = 0;
  int csb_low_total = 0;
  int viol_total = 0;
  int hi_run = 0;
  int last_gap = 0;

  always @(posedge flash_clk) sck_total = sck_total + 1;

  always @(negedge clock) begin
    if (rd_valid === 1'b1 && rd_ready) rx_q.push_back(rd_data);
    if (flash_csb === 1'b0) csb_low_total = csb_low_total + 1;
    if (req_ready === 1'b1 && busy === 1'b1) viol_total = viol_total + 1;
    if (flash_csb === 1'b1) hi_run = hi_run + 1;
    else begin
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [23:0] a, input logic [7:0] l, input bit keep, output bit ok);
    req_addr = a;
    req_len = l;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      ok = req_ready;
      tick();
    end
    req_valid = keep;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL reset_csb got %b expected 1", flash_csb); end
    checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL reset_clk got %b expected 0", flash_clk); end
    checks++; if (flash_io0 !== 1'b0) begin errors++; $display("FAIL reset_io0 got %b expected 0", flash_io0); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h expected 00", rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
    resetb = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic_read();
    logic [7:0] exp_b [4] = '{8'h6F, 8'h00, 8'h00, 8'h0B};
    int q0 = rx_q.size();
    int l0 = csb_low_total;
    int s0 = sck_total;
    int n = 0;
    bit ok;
    send_req(24'h000000, 8'd4, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept got timeout expected accept"); end
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (flash_csb) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL basic_csb_rise got timeout expected csb high"); end
    while (busy && n < 100) begin n++; tick(); end
    checks++; if (n != CS_GAP) begin errors++; $display("FAIL basic_busy_fall got %0d expected %0d", n, CS_GAP); end
    repeat (2) tick();
    checks++; if (csb_low_total - l0 != 258) begin errors++; $display("FAIL basic_csb_low got %0d expected 258", csb_low_total - l0); end
    checks++; if (sck_total - s0 != 64) begin errors++; $display("FAIL basic_pulses got %0d expected 64", sck_total - s0); end
    checks++; if (rx_q.size() - q0 != 4) begin errors++; $display("FAIL basic_count got %0d expected 4", rx_q.size() - q0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[q0 + i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d got %h expected %h", i, rx_q[q0 + i], exp_b[i]); end
    end
  endtask

  task automatic test_cmd_addr();
    int q0 = rx_q.size();
    bit ok;
    send_req(24'hAB40C1, 8'd1, 1'b0, ok);
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cmd_idle got timeout expected idle"); end
    checks++; if (fl_cmd !== 32'h03AB40C1) begin errors++; $display("FAIL cmd_word got %h expected 03ab40c1", fl_cmd); end
    checks++; if (rx_q.size() - q0 != 1) begin errors++; $display("FAIL cmd_count got %0d expected 1", rx_q.size() - q0); end
    checks++; if (rx_q[q0] !== 8'h9B) begin errors++; $display("FAIL cmd_byte got %h expected 9b", rx_q[q0]); end
  endtask

  task automatic test_len_zero();
    int q0 = rx_q.size();
    int s0 = sck_total;
    int bad = 0;
    bit ok;
    send_req(24'h000100, 8'd0, 1'b0, ok);
    wait_idle(12000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len0_idle got timeout expected idle"); end
    checks++; if (rx_q.size() - q0 != 256) begin errors++; $display("FAIL len0_count got %0d expected 256", rx_q.size() - q0); end
    checks++; if (sck_total - s0 != 2080) begin errors++; $display("FAIL len0_pulses got %0d expected 2080", sck_total - s0); end
    for (int j = 0; j < 256; j++) if (rx_q[q0 + j] !== (8'(j) ^ 8'h5A)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL len0_bytes got %0d wrong bytes expected 0", bad); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [3] = '{8'h4A, 8'h4B, 8'h48};
    int q0 = rx_q.size();
    int s0 = sck_total;
    int s1;
    int highs = 0;
    bit ok;
    rd_ready = 1'b1;
    send_req(24'h000010, 8'd3, 1'b0, ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (rx_q.size() > q0) begin ok = 1'b1; break; end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_first got timeout expected byte"); end
    repeat (100) tick();
    s1 = sck_total;
    for (int k = 0; k < 100; k++) begin
      if (flash_clk !== 1'b0) highs++;
      tick();
    end
    checks++; if (sck_total != s1) begin errors++; $display("FAIL bp_edges got %0d expected 0", sck_total - s1); end
    checks++; if (highs != 0) begin errors++; $display("FAIL bp_clk_low got %0d high samples expected 0", highs); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL bp_pending got %b expected 1", rd_valid); end
    rd_ready = 1'b1;
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_idle got timeout expected idle"); end
    checks++; if (rx_q.size() - q0 != 3) begin errors++; $display("FAIL bp_count got %0d expected 3", rx_q.size() - q0); end
    checks++; if (sck_total - s0 != 56) begin errors++; $display("FAIL bp_pulses got %0d expected 56", sck_total - s0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_q[q0 + i] !== exp_b[i]) begin errors++; $display("FAIL bp_byte%0d got %h expected %h", i, rx_q[q0 + i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int s0 = sck_total;
    int q0;
    bit ok;
    send_req(24'h000000, 8'd4, 1'b0, ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (sck_total - s0 >= 20) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_pulses got timeout expected 20 pulses"); end
    checks++; if (flash_clk !== 1'b1 || flash_csb !== 1'b0) begin errors++; $display("FAIL rst_pre got clk=%b csb=%b expected clk=1 csb=0", flash_clk, flash_csb); end
    #2;
    resetb = 1'b0;
    #1;
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL rst_csb got %b expected 1", flash_csb); end
    checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL rst_clk got %b expected 0", flash_clk); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b expected 0", rd_valid); end
    repeat (3) tick();
    resetb = 1'b1;
    repeat (2) tick();
    q0 = rx_q.size();
    send_req(24'h000004, 8'd1, 1'b0, ok);
    wait_idle(3000, ok);
    checks++; if (rx_q.size() - q0 != 1) begin errors++; $display("FAIL rst_follow_count got %0d expected 1", rx_q.size() - q0); end
    checks++; if (rx_q[q0] !== 8'hC3) begin errors++; $display("FAIL rst_follow_byte got %h expected c3", rx_q[q0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3] = '{8'h7A, 8'h7B, 8'h6A};
    int q0 = rx_q.size();
    int v0 = viol_total;
    bit ok1, ok2, ok3;
    send_req(24'h000020, 8'd2, 1'b1, ok1);
    send_req(24'h000030, 8'd1, 1'b0, ok2);
    wait_idle(3000, ok3);
    checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL b2b_handshake got %b%b%b expected 111", ok1, ok2, ok3); end
    checks++; if (viol_total != v0) begin errors++; $display("FAIL b2b_ready_busy got %0d cycles expected 0", viol_total - v0); end
    checks++; if (last_gap < CS_GAP) begin errors++; $display("FAIL b2b_gap got %0d expected >= %0d", last_gap, CS_GAP); end
    checks++; if (rx_q.size() - q0 != 3) begin errors++; $display("FAIL b2b_count got %0d expected 3", rx_q.size() - q0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_q[q0 + i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d got %h expected %h", i, rx_q[q0 + i], exp_b[i]); end
    end
  endtask

  initial begin
    #2;
    resetb = 1'b0;
    repeat (3) tick();
    test_reset();
    test_basic_read();
    test_cmd_addr();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
